// File: rtl/audio_pkg.sv
// Shared types and constants for the audio recorder/player datapath.
// Holds the SRAM arbiter state encoding and access timing default.
package audio_pkg;

  localparam int unsigned ADDR_W      = 20;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned ACC_CYC_DEF = 2;

  localparam int unsigned REC_BLK_WORDS  = 512;
  localparam int unsigned PLAY_BLK_WORDS = 512;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RECOVER
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin select for the SRAM arbiter.
// Bit 0 is the recorder (write), bit 1 the player (read).
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

  logic last_rd;

  always_comb begin
    o_gnt = 2'b00;
    unique case (1'b1)
      (i_req == 2'b11): o_gnt = last_rd ? 2'b01 : 2'b10;
      (i_req == 2'b01): o_gnt = 2'b01;
      (i_req == 2'b10): o_gnt = 2'b10;
      default:          o_gnt = 2'b00;
    endcase
  end

  // Starting from "read" hands the first contested slot to the recorder.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_rd <= 1'b1;
    end else if (i_take && |i_req) begin
      last_rd <= o_gnt[1];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between the recorder (writes) and player (reads).
// Fixed-length strobe window, one recovery cycle between accesses.
module sram_arbiter
  import audio_pkg::*;
#(
  parameter int unsigned ACC_CYC = ACC_CYC_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_req,
  input  logic [19:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  output logic        o_wr_ack,
  input  logic        i_rd_req,
  input  logic [19:0] i_rd_addr,
  output logic        o_rd_ack,
  output logic [15:0] o_rd_data,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_dq,
  input  logic [15:0] i_sram_dq,
  output logic        o_sram_dq_oe,
  output logic        o_sram_ce_n,
  output logic        o_sram_we_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n,
  output logic [19:0] o_max_addr,
  output logic        o_busy
);

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] gnt;
  logic       take;

  assign take   = (state == S_IDLE);
  assign o_busy = (state != S_IDLE);

  rr_arb2 u_rr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   ({i_rd_req, i_wr_req}),
    .i_take  (take),
    .o_gnt   (gnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      o_wr_ack     <= 1'b0;
      o_rd_ack     <= 1'b0;
      o_rd_data    <= '0;
      o_max_addr   <= '0;
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      o_sram_dq_oe <= 1'b0;
      o_sram_ce_n  <= 1'b1;
      o_sram_we_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_lb_n  <= 1'b1;
      o_sram_ub_n  <= 1'b1;
    end else begin
      o_wr_ack <= 1'b0;
      o_rd_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|gnt) begin
            cnt         <= 4'(ACC_CYC);
            o_sram_ce_n <= 1'b0;
            o_sram_lb_n <= 1'b0;
            o_sram_ub_n <= 1'b0;
            if (gnt[0]) begin
              state        <= S_WRITE;
              o_sram_addr  <= i_wr_addr;
              o_sram_dq    <= i_wr_data;
              o_sram_dq_oe <= 1'b1;
              o_sram_we_n  <= 1'b0;
            end else begin
              state       <= S_READ;
              o_sram_addr <= i_rd_addr;
              o_sram_oe_n <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state        <= S_RECOVER;
            o_wr_ack     <= 1'b1;
            o_sram_dq_oe <= 1'b0;
            o_sram_ce_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
            o_sram_lb_n  <= 1'b1;
            o_sram_ub_n  <= 1'b1;
            if (o_sram_addr > o_max_addr)
              o_max_addr <= o_sram_addr;
          end
        end
        S_READ: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= S_RECOVER;
            o_rd_ack    <= 1'b1;
            o_rd_data   <= i_sram_dq;
            o_sram_ce_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_sram_lb_n <= 1'b1;
            o_sram_ub_n <= 1'b1;
          end
        end
        S_RECOVER: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a transaction-level reference
// model, a behavioural SRAM and randomized recorder/player traffic.
module tb_sram_arbiter;

  localparam int ACC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req = 1'b0;
  logic [19:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic [19:0] rd_addr = '0;
  logic        wr_ack, rd_ack;
  logic [15:0] rd_data;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i = '0;
  logic        dq_oe, ce_n, we_n, oe_n, lb_n, ub_n;
  logic [19:0] max_addr;
  logic        busy;

  always #5 clk = ~clk;

  sram_arbiter #(.ACC_CYC(ACC)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wr_req     (wr_req),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_wr_ack     (wr_ack),
    .i_rd_req     (rd_req),
    .i_rd_addr    (rd_addr),
    .o_rd_ack     (rd_ack),
    .o_rd_data    (rd_data),
    .o_sram_addr  (sram_addr),
    .o_sram_dq    (sram_dq_o),
    .i_sram_dq    (sram_dq_i),
    .o_sram_dq_oe (dq_oe),
    .o_sram_ce_n  (ce_n),
    .o_sram_we_n  (we_n),
    .o_sram_oe_n  (oe_n),
    .o_sram_lb_n  (lb_n),
    .o_sram_ub_n  (ub_n),
    .o_max_addr   (max_addr),
    .o_busy       (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural SRAM device
  logic [15:0] sram_mem [logic [19:0]];
  always @(negedge clk) begin
    if (!ce_n && !we_n && dq_oe) sram_mem[sram_addr] = sram_dq_o;
    if (!ce_n && !oe_n && sram_mem.exists(sram_addr))
      sram_dq_i = sram_mem[sram_addr];
    else
      sram_dq_i = 16'h0;
  end

  // Reference model: one access at a time, round-robin on contention
  typedef struct {
    bit          wr;
    int          ack_at;
    logic [19:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [logic [19:0]];
  int          cyc = 0;
  int          free_at = 0;
  bit          last_rd = 1'b1;
  bit          pick_wr;
  exp_t        ne;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      free_at = 0;
      last_rd = 1'b1;
    end else if (cyc >= free_at && (wr_req || rd_req)) begin
      pick_wr = wr_req && (!rd_req || last_rd);
      ne.wr = pick_wr;
      ne.ack_at = cyc + ACC;
      if (pick_wr) begin
        ne.addr = wr_addr;
        ne.data = wr_data;
        ref_mem[wr_addr] = wr_data;
      end else begin
        ne.addr = rd_addr;
        ne.data = ref_mem.exists(rd_addr) ? ref_mem[rd_addr] : 16'h0;
      end
      sb.push_back(ne);
      last_rd = !pick_wr;
      free_at = cyc + ACC + 2;
    end
  end

  // Monitor
  int          rd_idx = 0;
  int          we_run = 0;
  int          oe_run = 0;
  int          n_rd_ack = 0;
  logic [19:0] exp_max = '0;
  logic [15:0] exp_rd = '0;
  bit          log_q[$];
  exp_t        ce;

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_idx = sb.size();
      exp_max = '0;
      exp_rd = '0;
      we_run = 0;
      oe_run = 0;
    end else begin
      chk("we_oe_exclusive", 32'(we_n | oe_n), 32'd1);
      if (!ce_n && we_run == 0 && oe_run == 0) begin
        chk("access_expected", 32'(rd_idx < sb.size()), 32'd1);
        if (rd_idx < sb.size()) begin
          ce = sb[rd_idx];
          chk("access_addr", 32'(sram_addr), 32'(ce.addr));
          chk("access_dir_we", 32'(we_n), 32'(!ce.wr));
          chk("access_dir_oe", 32'(oe_n), 32'(ce.wr));
          chk("access_dq_oe", 32'(dq_oe), 32'(ce.wr));
          chk("access_lb_ub", 32'({lb_n, ub_n}), 32'd0);
          if (ce.wr) chk("access_wdata", 32'(sram_dq_o), 32'(ce.data));
        end
      end
      if (!we_n) we_run++;
      else if (we_run > 0) begin
        chk("we_low_cycles", 32'(we_run), 32'(ACC));
        we_run = 0;
      end
      if (!oe_n) oe_run++;
      else if (oe_run > 0) begin
        chk("oe_low_cycles", 32'(oe_run), 32'(ACC));
        oe_run = 0;
      end
      if (wr_ack || rd_ack) begin
        chk("ack_expected", 32'(rd_idx < sb.size()), 32'd1);
        if (rd_idx < sb.size()) begin
          ce = sb[rd_idx];
          rd_idx++;
          chk("ack_cycle", 32'(cyc), 32'(ce.ack_at));
          chk("ack_kind", 32'({wr_ack, rd_ack}), ce.wr ? 32'd2 : 32'd1);
          chk("ack_ce_high", 32'(ce_n), 32'd1);
          if (ce.wr) begin
            if (ce.addr > exp_max) exp_max = ce.addr;
          end else begin
            exp_rd = ce.data;
            n_rd_ack++;
          end
          chk("max_addr", 32'(max_addr), 32'(exp_max));
          chk("rd_data", 32'(rd_data), 32'(exp_rd));
          log_q.push_back(ce.wr);
        end
      end else if (rd_idx < sb.size() && cyc > sb[rd_idx].ack_at) begin
        chk("ack_timeout", 32'(cyc), 32'(sb[rd_idx].ack_at));
        rd_idx++;
      end
    end
  end

  // Requesters
  task automatic do_wr(input logic [19:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_req = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_ack) break;
    end
    chk("wr_ack_seen", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
  endtask

  task automatic do_rd(input logic [19:0] a, input bit drop);
    bit dropped;
    dropped = 1'b0;
    @(negedge clk);
    rd_req = 1'b1;
    rd_addr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd_ack) break;
      if (drop && !dropped && !oe_n) begin
        @(negedge clk);
        if (rd_ack) break;
        rd_req = 1'b0;
        dropped = 1'b1;
      end
    end
    chk("rd_ack_seen", 32'(rd_ack), 32'd1);
    rd_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_idx == sb.size() && !busy) break;
    end
    chk("drained", 32'(rd_idx == sb.size() && !busy), 32'd1);
  endtask

  int base;
  int acks0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1f);
    chk("rst_dq_oe", 32'(dq_oe), 32'd0);
    chk("rst_acks", 32'({wr_ack, rd_ack}), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_max_addr", 32'(max_addr), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    do_wr(20'h00010, 16'hBEEF);
    chk("max_after_write", 32'(max_addr), 32'h10);
    do_rd(20'h00010, 1'b0);
    chk("read_back", 32'(rd_data), 32'hBEEF);

    do_wr(20'h000FF, 16'h1111);
    do_wr(20'h00005, 16'h2222);
    chk("max_holds", 32'(max_addr), 32'hFF);

    acks0 = n_rd_ack;
    do_rd(20'h00005, 1'b1);
    repeat (6) @(negedge clk);
    chk("dropped_rd_acks", 32'(n_rd_ack - acks0), 32'd1);
    chk("dropped_rd_data", 32'(rd_data), 32'h2222);

    base = log_q.size();
    @(negedge clk);
    wr_req = 1'b1;
    wr_addr = 20'h00020;
    wr_data = 16'h5A5A;
    rd_req = 1'b1;
    rd_addr = 20'h00010;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (log_q.size() >= base + 8) break;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk("rr_count", 32'(log_q.size() >= base + 8), 32'd1);
    if (log_q.size() >= base + 8)
      for (int i = 0; i < 8; i++)
        chk($sformatf("rr_order_%0d", i), 32'(log_q[base + i]),
            32'(i % 2 == 0));
    drain();

    @(negedge clk);
    wr_req = 1'b1;
    wr_addr = 20'h00ABC;
    wr_data = 16'hC0DE;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!we_n) break;
    end
    chk("abort_we_seen", 32'(we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_strobes", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1f);
    chk("abort_dq_oe", 32'(dq_oe), 32'd0);
    chk("abort_max", 32'(max_addr), 32'd0);
    wr_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ack", 32'({wr_ack, rd_ack}), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle", 32'({busy, wr_ack, rd_ack}), 32'd0);

    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          if ($urandom_range(0, 7) == 0)
            do_wr(20'($urandom), 16'($urandom));
          else
            do_wr(20'($urandom_range(0, 15)), 16'($urandom));
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          do_rd(20'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACC_CYC, default 2, SRAM strobe-low cycles per access (legal range 1..15).
REQ-002 i_clk  in  1  system clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_wr_req  in  1  recorder write request; held high with address and data stable until o_wr_ack.
REQ-005 i_wr_addr  in  20  write word address.
REQ-006 i_wr_data  in  16  write word.
REQ-007 o_wr_ack  out  1  one-cycle pulse: write completed.
REQ-008 i_rd_req  in  1  player read request; held high with address stable until o_rd_ack.
REQ-009 i_rd_addr  in  20  read word address.
REQ-010 o_rd_ack  out  1  one-cycle pulse: o_rd_data valid this cycle.
REQ-011 o_rd_data  out  16  read word; holds until next read completes.
REQ-012 o_sram_addr  out  20  SRAM address.
REQ-013 o_sram_dq  out  16  SRAM write data; i_sram_dq  in  16  SRAM read data; o_sram_dq_oe  out  1  high drives pad.
REQ-014 o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active-low.
REQ-015 o_max_addr  out  20  highest address written since reset; o_busy  out  1  high outside S_IDLE.

Function
REQ-016 States: S_IDLE, S_WRITE, S_READ, S_RECOVER.
REQ-017 S_IDLE: one request -> grant it; both -> grant opposite of last grant (round-robin); none -> stay.
REQ-018 On grant, address, write data and direction are latched into registers; requester inputs are not sampled again until next grant.
REQ-019 S_WRITE: we_n low, dq_oe high, for exactly ACC_CYC cycles; oe_n high throughout.
REQ-020 S_READ: oe_n low, dq_oe low, for exactly ACC_CYC cycles; i_sram_dq captured on the last cycle.
REQ-021 o_wr_ack / o_rd_ack pulse high on the first S_RECOVER cycle; S_RECOVER lasts one cycle with all strobes high, then S_IDLE.
REQ-022 Latency grant-to-ack is ACC_CYC+1 cycles; request-to-next-grant minimum ACC_CYC+2 cycles (bus turnaround guaranteed).
REQ-023 ce_n, lb_n, ub_n low in S_WRITE and S_READ, high otherwise; we_n and oe_n never low simultaneously.
REQ-024 A request dropped mid-access does not abort; access completes and ack is still pulsed.
REQ-025 Requester holding req high through its ack cycle is treated as a new request in the following S_IDLE.
REQ-026 On each completed write, o_max_addr <= max(o_max_addr, latched address); no wrap, 20-bit compare.
REQ-027 Access counter is 4-bit, reloaded on every grant.

Reset
REQ-028 Reset forces state S_IDLE, all strobes high, dq_oe low, acks low, o_rd_data 0, o_max_addr 0, o_sram_addr 0, counter 0.
REQ-029 Last-grant register resets to read, so the first contested grant goes to write.
REQ-030 Reset asserted mid-access: strobes deassert immediately; no ack issued for the aborted access.

Structure
REQ-031 State enum and ACC_CYC default live in shared package audio_pkg alongside recorder/player constants.
REQ-032 Round-robin select is one sub-module, rr_arb2 (two requests, last-grant register, grant one-hot); remainder is flat.

Verification
REQ-033 Single write addr 0x00010 data 0xBEEF, ACC_CYC=2 -> we_n low 2 cycles, o_wr_ack at grant+3, o_max_addr=0x00010.
REQ-034 Read addr 0x00010 after REQ-033 with model returning 0xBEEF -> o_rd_ack at grant+3, o_rd_data=0xBEEF, oe_n low 2 cycles.
REQ-035 Both requests held continuously 8 accesses -> grants alternate W,R,W,R..., write first, one S_RECOVER between each.
REQ-036 Write 0x000FF then 0x00005 -> o_max_addr stays 0x000FF.
REQ-037 i_rd_req dropped one cycle after grant -> read completes, o_rd_ack pulses once.
REQ-038 i_rst_n low during S_WRITE -> strobes high same cycle, no ack, o_max_addr=0.
